// File: rtl/wb_wr_arbiter.sv
// wb_wr_arbiter
//   Shares the single register-file write port between the in-order
//   writeback stage and out-of-order results from long-latency units such as
//   the divider. A WB write always goes first. Unit results wait in a small
//   in-order FIFO and drain on cycles where WB does not write. If the FIFO
//   head is blocked for too long, a bubble is requested from the hazard unit.
//   Pending-destination lookups let the hazard unit stall RAW/WAW consumers
//   of queued results.
//
// Parameters
//   DEPTH     unit-result FIFO entries (power of 2, >= 2)
//   MAX_WAIT  consecutive blocked cycles of the head before pipe_stall_req
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   wb_reg_wdata/_wr_reg_en/_reg_addr   WB stage write request
//   div_valid/div_ready                 unit result handshake
//   div_waddr/div_wdata                 unit result destination and data
//   rf_wr_en/rf_wr_addr/rf_wdata        register-file write port
//   pipe_stall_req                      bubble request to the hazard unit
//   chk_addr1/2 -> chk_hit1/2           pending-destination lookup
module wb_wr_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_reg_wdata,
    input  logic        wb_wr_reg_en,
    input  logic [4:0]  wb_wr_reg_addr,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [4:0]  div_waddr,
    input  logic [31:0] div_wdata,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall_req,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_hit1,
    output logic        chk_hit2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            stall_q, stall_d;

    logic empty, full, wb_busy, deq, store;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign div_ready = !full;
    assign wb_busy   = wb_wr_reg_en && (wb_wr_reg_addr != 5'd0);
    assign deq       = !wb_busy && !empty;
    // Writes to x0 are accepted to keep the producer moving but never stored.
    assign store     = div_valid && div_ready && (div_waddr != 5'd0);

    assign pipe_stall_req = stall_q;

    // Write port mux: WB first, then FIFO head, else idle with zeroed outputs.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = 5'd0;
        rf_wdata   = 32'd0;
        if (wb_busy) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = wb_wr_reg_addr;
            rf_wdata   = wb_reg_wdata;
        end else if (!empty) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = mem_q[rd_ptr_q].addr;
            rf_wdata   = mem_q[rd_ptr_q].data;
        end
    end

    // FIFO next state; simultaneous store and dequeue leave the count alone.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            mem_d[wr_ptr_q] = '{addr: div_waddr, data: div_wdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({store, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Starvation tracking. When the FIFO is non-empty and the head is not
    // dequeued, the head is by construction blocked by a WB write.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        if (empty || deq) begin
            wait_cnt_d = '0;
            stall_d    = 1'b0;
        end else begin
            if (wait_cnt_q == WW'(MAX_WAIT)) begin
                stall_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    // Pending-destination lookup: an entry is live if its distance from the
    // read pointer is below the count.
    always_comb begin
        chk_hit1 = 1'b0;
        chk_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                if (chk_addr1 != 5'd0 && mem_q[i].addr == chk_addr1) chk_hit1 = 1'b1;
                if (chk_addr2 != 5'd0 && mem_q[i].addr == chk_addr2) chk_hit2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_wb_wr_arbiter.sv
// Directed bench for wb_wr_arbiter (DEPTH=2, MAX_WAIT=4). Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_wb_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_reg_wdata;
    logic        wb_wr_reg_en;
    logic [4:0]  wb_wr_reg_addr;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wdata;
    logic        pipe_stall_req;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_hit1, chk_hit2;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    wb_wr_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_reg_wdata   (wb_reg_wdata),
        .wb_wr_reg_en   (wb_wr_reg_en),
        .wb_wr_reg_addr (wb_wr_reg_addr),
        .div_valid      (div_valid),
        .div_ready      (div_ready),
        .div_waddr      (div_waddr),
        .div_wdata      (div_wdata),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wdata       (rf_wdata),
        .pipe_stall_req (pipe_stall_req),
        .chk_addr1      (chk_addr1),
        .chk_addr2      (chk_addr2),
        .chk_hit1       (chk_hit1),
        .chk_hit2       (chk_hit2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_wr_reg_en   = en;
        wb_wr_reg_addr = a;
        wb_reg_wdata   = d;
    endtask

    task automatic push(input logic v, input logic [4:0] a, input logic [31:0] d);
        div_valid = v;
        div_waddr = a;
        div_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        push(1'b0, 5'd0, 32'd0);
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd0;

        // Reset state
        smp();
        chk("rst_ready", 32'(div_ready), 32'd1);
        chk("rst_wren", 32'(rf_wr_en), 32'd0);
        chk("rst_stall", 32'(pipe_stall_req), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: reset with two entries queued
        wb(1'b1, 5'd3, 32'h3333);
        push(1'b1, 5'd8, 32'h88);
        cyc();
        push(1'b1, 5'd9, 32'h99);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        chk_addr1 = 5'd8;
        chk_addr2 = 5'd9;
        smp();
        chk("t1_full_ready", 32'(div_ready), 32'd0);
        chk("t1_pre_hit1", 32'(chk_hit1), 32'd1);
        chk("t1_pre_hit2", 32'(chk_hit2), 32'd1);
        rst_n = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("t1_rst_ready", 32'(div_ready), 32'd1);
        chk("t1_rst_hit1", 32'(chk_hit1), 32'd0);
        chk("t1_rst_hit2", 32'(chk_hit2), 32'd0);
        chk("t1_rst_stall", 32'(pipe_stall_req), 32'd0);
        chk("t1_rst_wren", 32'(rf_wr_en), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        smp();
        chk("t1_post_wren", 32'(rf_wr_en), 32'd0);
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd0;
        cyc();

        // 2: idle WB, single push drains the next cycle
        push(1'b1, 5'd5, 32'h1234);
        smp();
        chk("t2_nobypass", 32'(rf_wr_en), 32'd0);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        smp();
        chk("t2_wren", 32'(rf_wr_en), 32'd1);
        chk("t2_addr", 32'(rf_wr_addr), 32'd5);
        chk("t2_data", rf_wdata, 32'h1234);
        cyc();
        smp();
        chk("t2_idle_wren", 32'(rf_wr_en), 32'd0);
        chk("t2_idle_addr", 32'(rf_wr_addr), 32'd0);
        chk("t2_idle_data", rf_wdata, 32'd0);
        cyc();

        // 3: starvation request
        wb(1'b1, 5'd3, 32'hAAAA);
        push(1'b1, 5'd7, 32'h77);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        smp();
        chk("t3_wb_prio_addr", 32'(rf_wr_addr), 32'd3);
        chk("t3_wb_prio_data", rf_wdata, 32'hAAAA);
        cyc(); cyc(); cyc();
        smp();
        chk("t3_stall_early", 32'(pipe_stall_req), 32'd0);
        cyc(); cyc(); cyc();
        smp();
        chk("t3_stall_set", 32'(pipe_stall_req), 32'd1);
        chk("t3_wb_kept", 32'(rf_wr_addr), 32'd3);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_drain_addr", 32'(rf_wr_addr), 32'd7);
        chk("t3_drain_data", rf_wdata, 32'h77);
        cyc();
        smp();
        chk("t3_stall_clr", 32'(pipe_stall_req), 32'd0);
        chk("t3_after_wren", 32'(rf_wr_en), 32'd0);
        cyc();

        // 4: full FIFO back-pressure and ordering
        wb(1'b1, 5'd3, 32'h3);
        push(1'b1, 5'd8, 32'h88);
        cyc();
        push(1'b1, 5'd9, 32'h99);
        cyc();
        push(1'b1, 5'd10, 32'hA0);
        chk_addr1 = 5'd10;
        smp();
        chk("t4_full", 32'(div_ready), 32'd0);
        cyc();
        smp();
        chk("t4_held_ready", 32'(div_ready), 32'd0);
        chk("t4_held_nohit", 32'(chk_hit1), 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("t4_w8_addr", 32'(rf_wr_addr), 32'd8);
        chk("t4_w8_data", rf_wdata, 32'h88);
        chk("t4_ready_reg", 32'(div_ready), 32'd0);
        cyc();
        wb(1'b1, 5'd3, 32'h3);
        smp();
        chk("t4_ready_back", 32'(div_ready), 32'd1);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        smp();
        chk("t4_held_hit", 32'(chk_hit1), 32'd1);
        chk("t4_stall", 32'(pipe_stall_req), 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("t4_w9_addr", 32'(rf_wr_addr), 32'd9);
        cyc();
        smp();
        chk("t4_w10_addr", 32'(rf_wr_addr), 32'd10);
        chk("t4_w10_data", rf_wdata, 32'hA0);
        cyc();
        smp();
        chk("t4_empty_wren", 32'(rf_wr_en), 32'd0);
        chk_addr1 = 5'd0;
        cyc();

        // 5: x0 result accepted but never written; WB to x0 is not a write
        push(1'b1, 5'd0, 32'hFFFF);
        wb(1'b1, 5'd0, 32'h5555);
        smp();
        chk("t5_ready", 32'(div_ready), 32'd1);
        chk("t5_wb_x0", 32'(rf_wr_en), 32'd0);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        smp();
        chk("t5_no_write", 32'(rf_wr_en), 32'd0);
        chk("t5_hit_x0", 32'(chk_hit1), 32'd0);
        cyc();
        smp();
        chk("t5_still_none", 32'(rf_wr_en), 32'd0);
        cyc();

        // 6: lookup against a queued entry, then after drain
        wb(1'b1, 5'd3, 32'h3);
        push(1'b1, 5'd9, 32'h9);
        cyc();
        push(1'b0, 5'd0, 32'd0);
        chk_addr1 = 5'd9;
        chk_addr2 = 5'd10;
        smp();
        chk("t6_hit1", 32'(chk_hit1), 32'd1);
        chk("t6_hit2", 32'(chk_hit2), 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        cyc();
        smp();
        chk("t6_drain_hit1", 32'(chk_hit1), 32'd0);
        chk("t6_drain_hit2", 32'(chk_hit2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
